// File: rtl/regbank_pkg.sv
// Shared types and width helpers for the register-bank write arbiter.
package regbank_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // A lock is released after the owner has been idle for this many cycles.
  localparam int unsigned LOCK_TIMEOUT = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request at or after ptr wins.
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter in front of a per-entry-enabled register bank.
// Optional owner lock with idle timeout when REGBANK_ARB_LOCK_EN is defined.
module regbank_wr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int SIZE      = 8,
  parameter  int BIT_WIDTH = 32,
  parameter  int ADDR_W    = $clog2(SIZE),
  localparam int SRC_W     = idx_w(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
`ifdef REGBANK_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                  req_lock,
`endif
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                clear,
  output logic [SIZE-1:0]                     bank_en,
  output logic [SIZE-1:0][BIT_WIDTH-1:0]      bank_d,
  output logic [SRC_W-1:0]                    wr_src,
  output logic                                addr_err
);

  localparam logic [ADDR_W:0] SIZE_L = (ADDR_W+1)'(SIZE);

  arb_state_t                     state_q, state_d;
  logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [SIZE-1:0]                bank_en_q, bank_en_d;
  logic [SIZE-1:0][BIT_WIDTH-1:0] bank_d_q, bank_d_d;
  logic [SRC_W-1:0]               wr_src_q, wr_src_d;
  logic                           addr_err_q, addr_err_d;

  logic [NUM_REQ-1:0] arb_req, arb_gnt;
  logic [SRC_W-1:0]   win, win_next;
  logic [ADDR_W-1:0]  win_addr;
  logic               xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (win)
  );

  // Clear and reset both suppress the grant so no transfer can slip through.
  assign req_ready = (reset || clear) ? '0 : arb_gnt;
  assign xfer      = |req_ready;
  assign win_next  = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign win_addr  = req_addr[win];

`ifdef REGBANK_ARB_LOCK_EN
  localparam int TMR_W = idx_w(LOCK_TIMEOUT);

  logic [SRC_W-1:0]   owner_q, owner_d, owner_next;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NUM_REQ-1:0] owner_mask;

  assign owner_next = (owner_q == SRC_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    arb_req = (state_q == LOCKED) ? (req_valid & owner_mask) : req_valid;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tmr_d    = tmr_q;
    rr_ptr_d = rr_ptr_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            rr_ptr_d = win_next;
            if (req_lock[win]) begin
              state_d = LOCKED;
              owner_d = win;
              tmr_d   = TMR_W'(LOCK_TIMEOUT - 1);
            end
          end
        end
        LOCKED: begin
          if (xfer) begin
            tmr_d = TMR_W'(LOCK_TIMEOUT - 1);
            if (!req_lock[win]) begin
              state_d  = IDLE;
              rr_ptr_d = win_next;
            end
          end else if (!req_valid[owner_q]) begin
            // Down-counter: the terminal count marks the last idle cycle.
            if (tmr_q == '0) begin
              state_d  = IDLE;
              rr_ptr_d = owner_next;
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end else begin
            tmr_d = TMR_W'(LOCK_TIMEOUT - 1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      tmr_q   <= '0;
    end else begin
      owner_q <= owner_d;
      tmr_q   <= tmr_d;
    end
  end
`else
  always_comb begin
    arb_req  = (state_q == IDLE) ? req_valid : '0;
    state_d  = IDLE;
    rr_ptr_d = xfer ? win_next : rr_ptr_q;
  end
`endif

  always_comb begin
    bank_en_d  = '0;
    bank_d_d   = bank_d_q;
    wr_src_d   = wr_src_q;
    addr_err_d = 1'b0;
    if (clear) begin
      bank_en_d = '1;
      bank_d_d  = '0;
    end else if (xfer) begin
      wr_src_d = win;
      if ({1'b0, win_addr} < SIZE_L) begin
        bank_en_d[win_addr] = 1'b1;
        bank_d_d[win_addr]  = req_data[win];
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      bank_en_q  <= '0;
      bank_d_q   <= '0;
      wr_src_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      bank_en_q  <= bank_en_d;
      bank_d_q   <= bank_d_d;
      wr_src_q   <= wr_src_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bank_en  = bank_en_q;
  assign bank_d   = bank_d_q;
  assign wr_src   = wr_src_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: vector table with a scoreboard queue, plus
// hand sequences for bad address, async reset and (when enabled) locking.
module tb_regbank_wr_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [3:0]        req_valid;
  logic [3:0][2:0]   req_addr;
  logic [3:0][31:0]  req_data;
  logic [3:0]        rdy8, rdy6;
  logic [7:0]        en8;
  logic [5:0]        en6;
  logic [7:0][31:0]  bd8;
  logic [5:0][31:0]  bd6;
  logic [1:0]        src8, src6;
  logic              err8, err6;
`ifdef REGBANK_ARB_LOCK_EN
  logic [3:0]        req_lock;
`endif

  always #5 clk = ~clk;

  regbank_wr_arbiter u8 (
    .clk(clk), .reset(reset), .req_valid(req_valid),
`ifdef REGBANK_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_addr(req_addr), .req_data(req_data), .req_ready(rdy8), .clear(clear),
    .bank_en(en8), .bank_d(bd8), .wr_src(src8), .addr_err(err8)
  );

  regbank_wr_arbiter #(.SIZE(6)) u6 (
    .clk(clk), .reset(reset), .req_valid(req_valid),
`ifdef REGBANK_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_addr(req_addr), .req_data(req_data), .req_ready(rdy6), .clear(clear),
    .bank_en(en6), .bank_d(bd6), .wr_src(src6), .addr_err(err6)
  );

  typedef struct {
    logic [3:0]      valid;
    logic [3:0][2:0] addr;
    logic            clr;
    logic [31:0]     d;
    logic [3:0]      rdy;
    logic [7:0]      en;
    logic [1:0]      src;
  } vec_t;

  typedef struct {
    logic [7:0]  en;
    logic [2:0]  a;
    logic [31:0] d;
    logic [1:0]  src;
    logic        xfer;
    logic        clr;
  } exp_t;

  localparam logic [11:0] FA = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [11:0] CA = {3'd6, 3'd5, 3'd3, 3'd1};
  localparam logic [11:0] SA = {3'd6, 3'd6, 3'd6, 3'd6};

  vec_t tbl[18];
  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [11:0] a, input logic c,
                              input logic [31:0] d, input logic [3:0] r,
                              input logic [7:0] e, input logic [1:0] s);
    vec_t t;
    t.valid = v; t.addr = a; t.clr = c; t.d = d; t.rdy = r; t.en = e; t.src = s;
    return t;
  endfunction

`ifdef REGBANK_ARB_LOCK_EN
  task automatic lk(input logic [3:0] v, input logic [3:0] l, input logic c,
                    input logic [3:0] r, input string nm);
    req_valid = v; req_lock = l; clear = c;
    @(negedge clk);
    chk(nm, rdy8, r);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t row;
    exp_t e;

    // Fairness: all valid, grants rotate 0..3 twice.
    for (int k = 0; k < 8; k++)
      tbl[k] = mk(4'hF, FA, 1'b0, 32'h1111_0000 + 32'(k), 4'(1 << (k % 4)),
                  8'(2 << (k % 4)), 2'(k % 4));
    tbl[8]  = mk(4'h0, FA, 1'b0, 32'h2222_0008, 4'h0, 8'h00, 2'd0);
    tbl[9]  = mk(4'hA, FA, 1'b0, 32'h2222_0009, 4'h2, 8'h04, 2'd1);
    tbl[10] = mk(4'hA, FA, 1'b0, 32'h2222_000A, 4'h8, 8'h10, 2'd3);
    tbl[11] = mk(4'h1, FA, 1'b0, 32'h2222_000B, 4'h1, 8'h02, 2'd0);
    tbl[12] = mk(4'h1, FA, 1'b0, 32'h2222_000C, 4'h1, 8'h02, 2'd0);
    tbl[13] = mk(4'h2, CA, 1'b1, 32'h3333_000D, 4'h0, 8'hFF, 2'd1);
    tbl[14] = mk(4'h2, CA, 1'b0, 32'h3333_000E, 4'h2, 8'h08, 2'd1);
    tbl[15] = mk(4'h4, CA, 1'b0, 32'hDEAD_BEEF, 4'h4, 8'h20, 2'd2);
    tbl[16] = mk(4'h9, SA, 1'b0, 32'hAAAA_0003, 4'h8, 8'h40, 2'd3);
    tbl[17] = mk(4'h1, SA, 1'b0, 32'h5555_0000, 4'h1, 8'h40, 2'd0);

    reset = 1'b1; clear = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef REGBANK_ARB_LOCK_EN
    req_lock = '0;
`endif
    #2;
    chk("rst_bank_en", en8, 8'h00);
    chk("rst_bank_d", |bd8, 1'b0);
    chk("rst_wr_src", src8, 2'd0);
    chk("rst_addr_err", err8, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 18; k++) begin
      row = tbl[k];
      req_valid = row.valid; req_addr = row.addr; clear = row.clr;
      for (int i = 0; i < 4; i++)
        req_data[i] = (i == int'(row.src)) ? row.d : (~row.d ^ 32'(i));
      @(negedge clk);
      chk($sformatf("ready_v%0d", k), rdy8, row.rdy);
      e.en = row.en; e.a = row.addr[row.src]; e.d = row.d; e.src = row.src;
      e.xfer = (row.rdy != 0) && !row.clr; e.clr = row.clr;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
        chk("sb_empty", 1'b1, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("bank_en_v%0d", k), en8, e.en);
        chk($sformatf("addr_err_v%0d", k), err8, 1'b0);
        if (e.clr) chk($sformatf("clr_data_v%0d", k), |bd8, 1'b0);
        if (e.xfer) begin
          chk($sformatf("wr_src_v%0d", k), src8, e.src);
          chk($sformatf("bank_d_v%0d", k), bd8[e.a], e.d);
        end
      end
    end
    clear = 1'b0;

    // Bad address on the SIZE=6 instance; pointer is at 1 so req0 wins on wrap.
    req_valid = 4'h1; req_addr = {3'd0, 3'd0, 3'd0, 3'd7}; req_data[0] = 32'hBAD0_0007;
    @(negedge clk);
    chk("bad_ready6", rdy6, 4'h1);
    @(posedge clk); #1;
    chk("bad_err6", err6, 1'b1);
    chk("bad_en6", en6, 6'h00);
    chk("bad_src6", src6, 2'd0);
    chk("bad_en8", en8, 8'h80);
    req_addr[0] = 3'd5; req_data[0] = 32'h0000_0005;
    @(negedge clk);
    chk("edge_ready6", rdy6, 4'h1);
    @(posedge clk); #1;
    chk("edge_err6", err6, 1'b0);
    chk("edge_en6", en6, 6'h20);
    chk("edge_d6", bd6[5], 32'h0000_0005);
    req_valid = 4'h0;
    @(posedge clk); #1;
    chk("idle_en6", en6, 6'h00);

    // Async reset while a write is on the bank outputs.
    req_valid = 4'h4; req_addr = {3'd0, 3'd2, 3'd0, 3'd0}; req_data[2] = 32'hCAFE_0002;
    @(negedge clk);
    chk("pre_rst_ready", rdy8, 4'h4);
    @(posedge clk); #1;
    chk("pre_rst_en", en8, 8'h04);
    req_valid = 4'hF; req_addr = FA;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_en", en8, 8'h00);
    chk("mid_rst_d8", |bd8, 1'b0);
    chk("mid_rst_d6", |bd6, 1'b0);
    chk("mid_rst_err6", err6, 1'b0);
    chk("mid_rst_ready", rdy8, 4'h0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("post_rst_ready", rdy8, 4'h1);
    @(posedge clk); #1;
    chk("post_rst_src", src8, 2'd0);
    chk("post_rst_en", en8, 8'h02);

`ifdef REGBANK_ARB_LOCK_EN
    req_valid = '0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    lk(4'h2, 4'h2, 1'b0, 4'h2, "lock_enter");
    for (int i = 0; i < 3; i++) lk(4'hB, 4'h2, 1'b0, 4'h2, "lock_hold");
    lk(4'hB, 4'h0, 1'b0, 4'h2, "lock_release");
    lk(4'hB, 4'h0, 1'b0, 4'h8, "after_release");
    lk(4'h2, 4'h2, 1'b0, 4'h2, "lock_enter2");
    for (int i = 0; i < 16; i++) lk(4'h9, 4'h0, 1'b0, 4'h0, "lock_idle_wait");
    lk(4'h9, 4'h0, 1'b0, 4'h8, "lock_timeout_release");
    lk(4'h2, 4'h2, 1'b0, 4'h2, "lock_enter3");
    lk(4'h9, 4'h0, 1'b1, 4'h0, "lock_clear");
    lk(4'h9, 4'h0, 1'b0, 4'h8, "after_lock_clear");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
